// File: rtl/r_type.sv
// RV64 R-type execution slice: 32 x XLEN register file with an external write
// port and a combinational ALU driven by the decoded R-type instruction.
module r_type #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic [4:0]      write_reg,
  input  logic [XLEN-1:0] write_data,
  input  logic            reg_write,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {
    F3_ADDSUB = 3'b000,
    F3_SLL    = 3'b001,
    F3_SLT    = 3'b010,
    F3_SLTU   = 3'b011,
    F3_XOR    = 3'b100,
    F3_SRLSRA = 3'b101,
    F3_OR     = 3'b110,
    F3_AND    = 3'b111
  } funct3_e;

  localparam logic [6:0] OP_R = 7'b0110011;

  logic [XLEN-1:0] r_regs [NREGS];

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  funct3_e         w_funct3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [6:0]      w_funct7;
  logic            w_alt;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [5:0]      w_shamt;
  logic            w_unused;

  assign w_opcode = instruction[6:0];
  assign w_rd     = instruction[11:7];
  assign w_funct3 = funct3_e'(instruction[14:12]);
  assign w_rs1    = instruction[19:15];
  assign w_rs2    = instruction[24:20];
  assign w_funct7 = instruction[31:25];
  assign w_alt    = w_funct7[5];
  assign w_shamt  = w_b[5:0];

  // rd and the remaining funct7 bits carry no meaning without internal writeback.
  assign w_unused = ^{w_rd, w_funct7[6], w_funct7[4:0], w_b[XLEN-1:6]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (reg_write && (write_reg != '0)) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // x0 is forced to zero on read so it stays zero even before the first reset.
  assign w_a = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
  assign w_b = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

  always_comb begin
    result = '0;
    if (w_opcode == OP_R) begin
      unique case (w_funct3)
        F3_ADDSUB: result = w_alt ? (w_a - w_b) : (w_a + w_b);
        F3_SLL:    result = w_a << w_shamt;
        F3_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
        F3_SLTU:   result = {{(XLEN-1){1'b0}}, (w_a < w_b)};
        F3_XOR:    result = w_a ^ w_b;
        F3_SRLSRA: result = w_alt ? XLEN'($signed(w_a) >>> w_shamt) : (w_a >> w_shamt);
        F3_OR:     result = w_a | w_b;
        F3_AND:    result = w_a & w_b;
        default:   result = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_r_type.sv
// Directed-vector bench for r_type: register loading, every ALU operation,
// x0 behaviour, read-during-write timing, asynchronous reset and non-R opcodes.
module tb_r_type;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic        reg_write;
  logic [63:0] result;

  int unsigned n_vec;
  int unsigned n_miss;

  r_type #(.XLEN(64), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [31:0] v);
    instruction = v;
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [63:0] data);
    reg_write  = 1'b1;
    write_reg  = idx;
    write_data = data;
    @(posedge clk);
    #1;
    reg_write  = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    reset       = 1'b0;
    reg_write   = 1'b0;
    write_reg   = '0;
    write_data  = '0;
    instruction = 32'h0063_8333;
    #1;
    check("rst_low_add", result, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_rel_add", result, 64'h0);

    for (int i = 0; i < 32; i++) wr(5'(i), 64'(i));

    set_instr(32'h0063_8333); check("add_x7_x6",   result, 64'd13);
    set_instr(32'h4063_8333); check("sub_x7_x6",   result, 64'd1);
    set_instr(32'h0011_71B3); check("and_x2_x1",   result, 64'd0);
    set_instr(32'h0011_61B3); check("or_x2_x1",    result, 64'd3);
    set_instr(32'h4042_E333); check("or_bit30",    result, 64'd5);
    set_instr(32'h4042_F3B3); check("and_bit30",   result, 64'd4);
    set_instr(32'h0050_01B3); check("add_x0_x5",   result, 64'd5);
    set_instr(32'h4010_01B3); check("sub_x0_x1",   result, 64'hFFFF_FFFF_FFFF_FFFF);
    set_instr(32'h0000_0013); check("non_r_addi",  result, 64'h0);
    set_instr(32'h0063_833B); check("non_r_op32",  result, 64'h0);

    wr(5'd0, 64'hDEAD_BEEF);
    set_instr(32'h0000_01B3); check("x0_discard",  result, 64'h0);

    wr(5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(5'd2, 64'd4);
    wr(5'd3, 64'h44);
    set_instr(32'h4020_D1B3); check("sra",         result, 64'hFFFF_FFFF_FFFF_FFFF);
    set_instr(32'h0020_D1B3); check("srl",         result, 64'h0FFF_FFFF_FFFF_FFFF);
    set_instr(32'h0030_D1B3); check("srl_shamt6",  result, 64'h0FFF_FFFF_FFFF_FFFF);
    set_instr(32'h0020_A1B3); check("slt",         result, 64'd1);
    set_instr(32'h0020_B1B3); check("sltu",        result, 64'd0);
    set_instr(32'h0010_81B3); check("add_wrap",    result, 64'hFFFF_FFFF_FFFF_FFFE);
    set_instr(32'h0020_91B3); check("sll",         result, 64'hFFFF_FFFF_FFFF_FFF0);
    set_instr(32'h0020_C1B3); check("xor",         result, 64'hFFFF_FFFF_FFFF_FFFB);
    set_instr(32'h4011_01B3); check("sub_x2_x1",   result, 64'd5);

    // Read of the register being written shows the old value until the edge.
    set_instr(32'h0001_01B3);
    reg_write  = 1'b1;
    write_reg  = 5'd2;
    write_data = 64'd9;
    #1;
    check("rdw_before",  result, 64'd4);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    check("rdw_after",   result, 64'd9);

    set_instr(32'h0063_8333); check("add_pre_rst", result, 64'd13);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_add", result, 64'h0);
    set_instr(32'h4042_E333); check("async_rst_or", result, 64'h0);
    wr(5'd5, 64'd77);
    check("rst_blocks_wr", result, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_or", result, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
